// File: rtl/speed_meter_if.sv
// Measurement bundle for speed_meter: enable and wheel pulse in,
// latched count, BCD digits and status out.
interface speed_meter_if;
  logic       i_en;
  logic       i_pulse;
  logic [8:0] o_speed;
  logic [3:0] o_hund;
  logic [3:0] o_tens;
  logic [3:0] o_ones;
  logic       o_overflow;
  logic       o_valid;
  logic       o_busy;

  modport master (
    output i_en, i_pulse,
    input  o_speed, o_hund, o_tens, o_ones, o_overflow, o_valid, o_busy
  );

  modport slave (
    input  i_en, i_pulse,
    output o_speed, o_hund, o_tens, o_ones, o_overflow, o_valid, o_busy
  );
endinterface

// File: rtl/speed_meter.sv
// Wheel speed meter: counts synchronized pulse edges over a fixed gate window,
// then converts the latched count to BCD with a double-dabble FSM.
//
// state | meaning
// IDLE  | waiting for a window end
// CONV  | 9 double-dabble iterations on the captured count
// DONE  | results latched, o_valid strobe
module speed_meter #(
  parameter int GATE_CYCLES = 1000,
  parameter int SPEED_SAT   = 511
) (
  input logic          i_clk,
  input logic          i_rst,
  speed_meter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, DONE = 2'd2} state_t;

  localparam logic [15:0] GATE_LAST = 16'(GATE_CYCLES - 1);
  localparam logic [8:0]  SAT       = 9'(SPEED_SAT);

  logic        sync1_q, sync2_q, prev_q;
  logic [15:0] gate_q, gate_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        sat_q, sat_d;
  state_t      state_q, state_d;
  logic [3:0]  iter_q, iter_d;
  logic [20:0] dd_q, dd_d, dd_nxt;
  logic [8:0]  cap_q, cap_d;
  logic        cap_ovf_q, cap_ovf_d;
  logic [8:0]  speed_q, speed_d;
  logic [11:0] bcd_q, bcd_d;
  logic        ovf_q, ovf_d;

  logic       edge_det, win_end, at_sat, final_sat;
  logic [8:0] final_cnt;

  // One iteration: {bcd[11:0], bin[8:0]}, add 3 to nibbles >= 5, shift left.
  function automatic logic [20:0] dd_step(input logic [20:0] v);
    logic [20:0] r;
    r = v;
    for (int i = 0; i < 3; i++) begin
      if (r[9 + 4*i +: 4] >= 4'd5) r[9 + 4*i +: 4] = r[9 + 4*i +: 4] + 4'd3;
    end
    return r << 1;
  endfunction

  assign edge_det  = sync2_q & ~prev_q;
  assign win_end   = bus.i_en && (gate_q == GATE_LAST);
  assign at_sat    = (cnt_q == SAT);
  assign final_cnt = (edge_det && !at_sat) ? cnt_q + 9'd1 : cnt_q;
  assign final_sat = sat_q | (edge_det & at_sat);
  assign dd_nxt    = dd_step(dd_q);

  // Window-end cycle folds its own edge into the result, then restarts at 0.
  always_comb begin
    gate_d = 16'd0;
    cnt_d  = 9'd0;
    sat_d  = 1'b0;
    if (bus.i_en && !win_end) begin
      gate_d = gate_q + 16'd1;
      cnt_d  = final_cnt;
      sat_d  = final_sat;
    end
  end

  always_comb begin
    state_d   = state_q;
    iter_d    = iter_q;
    dd_d      = dd_q;
    cap_d     = cap_q;
    cap_ovf_d = cap_ovf_q;
    speed_d   = speed_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (win_end) begin
          state_d   = CONV;
          dd_d      = {12'd0, final_cnt};
          cap_d     = final_cnt;
          cap_ovf_d = final_sat;
          iter_d    = 4'd8;
        end
      end
      CONV: begin
        dd_d   = dd_nxt;
        iter_d = iter_q - 4'd1;
        if (iter_q == 4'd0) begin
          state_d = DONE;
          speed_d = cap_q;
          bcd_d   = dd_nxt[20:9];
          ovf_d   = cap_ovf_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      gate_q    <= 16'd0;
      cnt_q     <= 9'd0;
      sat_q     <= 1'b0;
      state_q   <= IDLE;
      iter_q    <= 4'd0;
      dd_q      <= 21'd0;
      cap_q     <= 9'd0;
      cap_ovf_q <= 1'b0;
      speed_q   <= 9'd0;
      bcd_q     <= 12'd0;
      ovf_q     <= 1'b0;
    end else begin
      sync1_q   <= bus.i_pulse;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      gate_q    <= gate_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      state_q   <= state_d;
      iter_q    <= iter_d;
      dd_q      <= dd_d;
      cap_q     <= cap_d;
      cap_ovf_q <= cap_ovf_d;
      speed_q   <= speed_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.o_speed    = speed_q;
  assign bus.o_hund     = bcd_q[11:8];
  assign bus.o_tens     = bcd_q[7:4];
  assign bus.o_ones     = bcd_q[3:0];
  assign bus.o_overflow = ovf_q;
  assign bus.o_valid    = (state_q == DONE);
  assign bus.o_busy     = (state_q != IDLE);
endmodule
